// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN call scheduler and car sequencer with cycle-counted travel and door dwell
module elevator_scheduler #(
  parameter int N_FLOORS      = 3,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_btn,
  output logic [N_FLOORS-1:0] floor_onehot,
  output logic [N_FLOORS-1:0] pending,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;
  localparam logic [26:0] TRAVEL_LAST = 27'(TRAVEL_CYCLES - 1);
  localparam logic [26:0] DOOR_LAST   = 27'(DOOR_CYCLES - 1);
  state_t              state, state_n;
  logic                dir, dir_n;
  logic [26:0]         timer, timer_n;
  logic [N_FLOORS-1:0] floor_n, pending_n;
  logic [N_FLOORS-1:0] below, above, step, step_below, step_above, arr_req;
  logic                req_above, req_below, further, cur_press;
  assign below      = floor_onehot - 1'b1;
  assign above      = ~(below | floor_onehot);
  assign step       = dir ? floor_onehot << 1 : floor_onehot >> 1;
  assign step_below = step - 1'b1;
  assign step_above = ~(step_below | step);
  assign arr_req    = pending | call_btn;
  assign req_above  = |(pending & above);
  assign req_below  = |(pending & below);
  assign further    = dir ? |(arr_req & step_above) : |(arr_req & step_below);
  assign cur_press  = |(call_btn & floor_onehot);
  assign motor_up   = state == MOVING && dir;
  assign motor_down = state == MOVING && !dir;
  assign door_open  = state == DOOR;
  assign busy       = state != IDLE;
  always_comb begin
    state_n   = state;
    dir_n     = dir;
    timer_n   = timer + 27'd1;
    floor_n   = floor_onehot;
    pending_n = pending | call_btn;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (|(pending & floor_onehot)) state_n = DOOR;
        else if (req_above && (dir || !req_below)) begin
          state_n = MOVING;
          dir_n   = 1'b1;
        end else if (req_below) begin
          state_n = MOVING;
          dir_n   = 1'b0;
        end
      end
      MOVING: if (timer == TRAVEL_LAST) begin
        floor_n = step;
        timer_n = '0;
        // a call for the arrival floor on the arrival cycle is served by this stop
        state_n = |(arr_req & step) ? DOOR : further ? MOVING : IDLE;
      end
      default: begin
        pending_n = pending | (call_btn & ~floor_onehot);
        if (cur_press) timer_n = '0;
        else if (timer == DOOR_LAST) begin
          state_n = IDLE;
          timer_n = '0;
        end
      end
    endcase
    if (state_n == DOOR && state != DOOR) pending_n = pending_n & ~floor_n;
  end
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir          <= 1'b1;
      timer        <= '0;
      floor_onehot <= N_FLOORS'(1);
      pending      <= '0;
    end else begin
      state        <= state_n;
      dir          <= dir_n;
      timer        <= timer_n;
      floor_onehot <= floor_n;
      pending      <= pending_n;
    end
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: table-driven cycle-by-cycle checks of the elevator scheduler
module tb_elevator_scheduler;
  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] call_btn = '0;
  logic [2:0] floor_onehot, pending;
  logic       motor_up, motor_down, door_open, busy;
  int tests = 0;
  int fails = 0;
  typedef struct {
    bit         rst;
    logic [2:0] call;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[$];
  elevator_scheduler #(.N_FLOORS(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .call_btn(call_btn), .floor_onehot(floor_onehot),
    .pending(pending), .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open), .busy(busy)
  );
  always #5 clk_50 = ~clk_50;
  function automatic logic [9:0] outs();
    return {floor_onehot, pending, motor_up, motor_down, door_open, busy};
  endfunction
  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got floor=%b pend=%b up/dn/door/busy=%b, expected floor=%b pend=%b up/dn/door/busy=%b",
               name, got[9:7], got[6:4], got[3:0], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask
  task automatic add(input int n, input bit r, input logic [2:0] c, input logic [2:0] f,
                     input logic [2:0] p, input logic up, input logic dn, input logic dr, input logic b);
    for (int i = 0; i < n; i++) vecs.push_back('{r && i == 0, c, {f, p, up, dn, dr, b}});
  endtask
  task automatic do_reset();
    call_btn = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_50);
    #1 check("reset_state", outs(), 10'b001_000_0000);
    @(negedge clk_50) rst_n = 1'b1;
  endtask
  initial begin
    // single far call
    add(1, 1, 3'b100, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b100, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b001, 3'b100, 1, 0, 0, 1);
    add(4, 0, 3'b000, 3'b010, 3'b100, 1, 0, 0, 1);
    add(3, 0, 3'b000, 3'b100, 3'b000, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b100, 3'b000, 0, 0, 0, 0);
    // same-floor call with door reload
    add(1, 1, 3'b001, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b001, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b000, 0, 0, 1, 1);
    add(1, 0, 3'b001, 3'b001, 3'b000, 0, 0, 1, 1);
    add(3, 0, 3'b000, 3'b001, 3'b000, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b001, 3'b000, 0, 0, 0, 0);
    // intermediate stop
    add(1, 1, 3'b100, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b100, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b100, 1, 0, 0, 1);
    add(1, 0, 3'b010, 3'b001, 3'b100, 1, 0, 0, 1);
    add(2, 0, 3'b000, 3'b001, 3'b110, 1, 0, 0, 1);
    add(3, 0, 3'b000, 3'b010, 3'b100, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b010, 3'b100, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b010, 3'b100, 1, 0, 0, 1);
    add(3, 0, 3'b000, 3'b100, 3'b000, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b100, 3'b000, 0, 0, 0, 0);
    // SCAN: down call during floor-1 door is served after floor 2
    add(1, 1, 3'b100, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b100, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b100, 1, 0, 0, 1);
    add(1, 0, 3'b010, 3'b001, 3'b100, 1, 0, 0, 1);
    add(2, 0, 3'b000, 3'b001, 3'b110, 1, 0, 0, 1);
    add(1, 0, 3'b000, 3'b010, 3'b100, 0, 0, 1, 1);
    add(1, 0, 3'b001, 3'b010, 3'b100, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b010, 3'b101, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b010, 3'b101, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b010, 3'b101, 1, 0, 0, 1);
    add(3, 0, 3'b000, 3'b100, 3'b001, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b100, 3'b001, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b100, 3'b001, 0, 1, 0, 1);
    add(4, 0, 3'b000, 3'b010, 3'b001, 0, 1, 0, 1);
    add(3, 0, 3'b000, 3'b001, 3'b000, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b001, 3'b000, 0, 0, 0, 0);
    // simultaneous calls
    add(1, 1, 3'b101, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b001, 3'b101, 0, 0, 0, 0);
    add(3, 0, 3'b000, 3'b001, 3'b100, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b001, 3'b100, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b001, 3'b100, 1, 0, 0, 1);
    add(4, 0, 3'b000, 3'b010, 3'b100, 1, 0, 0, 1);
    add(3, 0, 3'b000, 3'b100, 3'b000, 0, 0, 1, 1);
    add(1, 0, 3'b000, 3'b100, 3'b000, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(posedge clk_50);
      #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      call_btn = vecs[i].call;
    end
    // asynchronous reset while the motor is running
    do_reset();
    @(posedge clk_50);
    #1 call_btn = 3'b100;
    @(posedge clk_50);
    #1 call_btn = 3'b000;
    for (int i = 0; i < 10 && !motor_up; i++) @(posedge clk_50) #1;
    check("motor_before_async_reset", {9'd0, motor_up}, 10'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_travel", outs(), 10'b001_000_0000);
    @(negedge clk_50) rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Call scheduler and car sequencer for the elevator controller. It latches hall/car calls from the floor buttons and chooses travel direction with a SCAN (continue-in-direction) policy. It times floor-to-floor travel and door dwell by counting `clk_50` cycles, and drives the motor, door and floor-indicator outputs. It is the consumer of the button/LED level signals and replaces ad-hoc slow-clock generation with explicit cycle timers.

## Interface

- `N_FLOORS`, 3, number of floors; floor 0 is the lowest; range 2..8.
- `TRAVEL_CYCLES`, 50000000, `clk_50` cycles to move one floor; range 1..2^27-1.
- `DOOR_CYCLES`, 100000000, `clk_50` cycles the door stays open; range 1..2^27-1.

- `clk_50`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `call_btn`  in  N_FLOORS  per-floor call; any cycle high registers a request.
- `floor_onehot`  out  N_FLOORS  current car floor, one-hot.
- `pending`  out  N_FLOORS  latched outstanding requests (button lamps).
- `motor_up`  out  1  car moving up.
- `motor_down`  out  1  car moving down.
- `door_open`  out  1  door open.
- `busy`  out  1  state is not IDLE.

## Operation

- **Reset values** (immediate on `rst_n` low, including mid-travel):
  - State IDLE.
  - `floor_onehot` = floor 0.
  - `pending` = 0; `motor_up` = `motor_down` = `door_open` = `busy` = 0.
  - Timer = 0; direction register = UP.
  - No position is remembered across reset.
- **Request latching:** every cycle, `pending <= pending | call_btn`, with two exceptions:
  - The current floor's bit is cleared on entry to DOOR.
  - A press of the current floor's button while in DOOR does not latch; it reloads the door timer instead.
- **States:**
  - **IDLE.** Evaluates registered `pending`, in this priority order:
    - `pending[cur]` → DOOR.
    - Requests exist above and (direction = UP or none exist below) → MOVING, direction UP.
    - Requests exist below → MOVING, direction DOWN.
    - Otherwise stay in IDLE.
  - **MOVING.**
    - Motor output for the held direction = 1; the timer counts 0..TRAVEL_CYCLES-1.
    - At terminal count the floor shifts one position and the timer returns to 0. Then, evaluating the new floor:
      - `pending[new]` → DOOR.
      - Requests exist further in the same direction → stay in MOVING.
      - Otherwise → IDLE (which reverses next cycle if requests exist behind).
  - **DOOR.**
    - `door_open` = 1, motors = 0; the timer counts 0..DOOR_CYCLES-1, then → IDLE.
    - `call_btn[cur]` high resets the timer to 0.
- **Output invariants:**
  - `motor_up` and `motor_down` are never high together.
  - A motor and `door_open` are never high together.
  - The car never moves past floor 0 or floor N_FLOORS-1.
- **Counters:** one shared 27-bit timer; it is cleared on every state change.

## Timing

- All outputs are registered and derived from state; `busy` = (state != IDLE).
- Request latency:
  - Call at cycle t → `pending` visible at t+1.
  - If the car is IDLE, the motor (or `door_open`, for a same-floor call) asserts at t+2.
- Travel: the motor is high for exactly TRAVEL_CYCLES cycles per floor. `floor_onehot` updates on the cycle after the last count, on the same edge as the next state.
- The motor stays continuously high across intermediate floors that are not stopped at.
- Door dwell: `door_open` is high for exactly DOOR_CYCLES cycles after the last reload; IDLE follows on the next cycle.
- Pending-clear timing: the `pending` bit of a served floor drops on the same edge that `door_open` rises.
- Simultaneous events:
  - A call for the floor being arrived at, on the arrival cycle, is served by that door opening.
  - Calls to other floors arriving in the same cycle are all latched.

## Test plan

Bench parameters: N_FLOORS=3, TRAVEL_CYCLES=4, DOOR_CYCLES=3. Cycle t0 = first call cycle after reset release.

- **Reset:** hold `rst_n`=0 for 2 cycles → `floor_onehot`=001, `pending`=000, all motor/door/`busy`=0; assert `rst_n`=0 while `motor_up`=1 → all outputs return to reset values before the next clock edge.
- **Single far call:** `call_btn`=100 for 1 cycle at t0 → expected:
  - `pending`=100 at t0+1.
  - `motor_up`=1 for t0+2..t0+9.
  - `floor_onehot`=010 at t0+6, then 100 at t0+10.
  - `door_open`=1 for t0+10..t0+12 and `pending`=000 at t0+10.
  - `busy`=0 at t0+13.
- **Same-floor call and door reload:** idle at floor 0, `call_btn`=001 at t0 → expected:
  - `door_open`=1 from t0+2.
  - Press 001 again at t0+3 → door stays open through t0+6, IDLE at t0+7, `pending` stays 000.
- **Intermediate stop:** call 100 at t0, call 010 at t0+3 → expected:
  - Stop at floor 1 at t0+6 with door open for t0+6..t0+8.
  - Resume `motor_up` at t0+10; floor 100 at t0+14.
- **SCAN order:** car going up toward floor 2, call 001 during the floor-1 door → serves floor 2 first, then `motor_down` to floor 0; `motor_up` and `motor_down` are never both 1.
- **Simultaneous calls:** idle at floor 0, `call_btn`=101 at t0 → door opens at floor 0 at t0+2 with `pending`=100, then moves up and arrives at floor 2 after 8 motor cycles.
